fpadd_sched: RTL and testbench

FPADD_SCHED -- requirements
Module: fpadd_sched

---
 rtl/fpadd_pkg.sv | 18 +
 rtl/fpadd_sched_arb.sv | 47 ++++
 rtl/fpadd_sched.sv | 129 ++++++++++++
 tb/tb_fpadd_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpadd_pkg.sv
// Shared types for the FP adder scheduler: FSM states, requester index and NORM timeout default.
package fpadd_pkg;

    localparam int unsigned NORM_MAX_DEFAULT = 24;

    typedef logic reqIdx_t;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StResp
    } schedState_t;

endpackage

// File: rtl/fpadd_sched_arb.sv
// Two-requester grant selection. FPADD_SCHED_RR_EN selects round-robin (with a last-grant
// register); otherwise requester 0 has fixed priority and the module is purely combinational.
module fpadd_sched_arb
    import fpadd_pkg::*;
(
`ifdef FPADD_SCHED_RR_EN
    input  logic       clk,
    input  logic       reset,
    input  logic       accept,
`endif
    input  logic       enable,
    input  logic [1:0] req_valid,
    output logic [1:0] grant
);

`ifdef FPADD_SCHED_RR_EN
    reqIdx_t lastGrant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant <= 1'b1;
        end else if (accept) begin
            lastGrant <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            // On contention the requester that did not win last time goes first.
            if (&req_valid) begin
                grant = lastGrant ? 2'b01 : 2'b10;
            end else begin
                grant = req_valid;
            end
        end
    end
`else
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/fpadd_sched.sv
// Control FSM sequencing a shared FP adder datapath for two requesters; arbitration mode is
// chosen by FPADD_SCHED_RR_EN (round-robin when defined, fixed priority to requester 0 otherwise).
module fpadd_sched
    import fpadd_pkg::*;
#(
    parameter int unsigned NORM_MAX = NORM_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    output logic [31:0] dp_opA,
    output logic [31:0] dp_opB,
    output logic        dp_load,
    output logic        dp_align_en,
    output logic        dp_add_en,
    output logic        dp_norm_en,
    output logic        dp_round_en,
    input  logic        dp_norm_done,
    input  logic [31:0] dp_result,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(NORM_MAX + 1);
    localparam logic [CntW-1:0] NormLimit = CntW'(NORM_MAX);

    schedState_t     state;
    reqIdx_t         owner;
    logic [CntW-1:0] normCnt;
    logic            arbEnable;
    logic            handshake;

    // Gated by reset so req_ready reads 0 while reset is held.
    assign arbEnable = (state == StIdle) && !reset;
    assign handshake = |req_ready;

    fpadd_sched_arb u_arb (
`ifdef FPADD_SCHED_RR_EN
        .clk      (clk),
        .reset    (reset),
        .accept   (handshake),
`endif
        .enable   (arbEnable),
        .req_valid(req_valid),
        .grant    (req_ready)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            owner       <= 1'b0;
            normCnt     <= '0;
            dp_opA      <= '0;
            dp_opB      <= '0;
            dp_load     <= 1'b0;
            dp_align_en <= 1'b0;
            dp_add_en   <= 1'b0;
            dp_norm_en  <= 1'b0;
            dp_round_en <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            dp_load     <= 1'b0;
            dp_align_en <= 1'b0;
            dp_add_en   <= 1'b0;
            dp_round_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (handshake) begin
                        dp_opA  <= req_ready[1] ? req_a1 : req_a0;
                        dp_opB  <= req_ready[1] ? req_b1 : req_b0;
                        owner   <= req_ready[1];
                        busy    <= 1'b1;
                        dp_load <= 1'b1;
                        state   <= StLoad;
                    end
                end
                StLoad: begin
                    dp_align_en <= 1'b1;
                    state       <= StAlign;
                end
                StAlign: begin
                    dp_add_en <= 1'b1;
                    state     <= StAdd;
                end
                StAdd: begin
                    dp_norm_en <= 1'b1;
                    normCnt    <= CntW'(1);
                    state      <= StNorm;
                end
                StNorm: begin
                    // A done in the limit cycle still counts as a normal completion.
                    if (dp_norm_done || normCnt == NormLimit) begin
                        dp_norm_en  <= 1'b0;
                        rsp_timeout <= !dp_norm_done;
                        dp_round_en <= 1'b1;
                        state       <= StRound;
                    end else begin
                        normCnt <= normCnt + CntW'(1);
                    end
                end
                StRound: begin
                    rsp_data  <= dp_result;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= StResp;
                end
                StResp: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched: latency, grant order, response hold, NORM timeout and
// mid-operation reset. The datapath is modelled by dp_norm_done timing plus a fixed dp_result.
module tb_fpadd_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [31:0] dp_opA, dp_opB;
    logic        dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_round_en;
    logic        dp_norm_done;
    logic [31:0] dp_result;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    int nChecks = 0;
    int nBad    = 0;
    int doneAt  = 1;   // NORM cycle (1-based) in which the model raises done; 0 = never
    int normSeen = 0;

    always #5 clk = ~clk;

    fpadd_sched #(.NORM_MAX(24)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a0      (req_a0),
        .req_b0      (req_b0),
        .req_a1      (req_a1),
        .req_b1      (req_b1),
        .dp_opA      (dp_opA),
        .dp_opB      (dp_opB),
        .dp_load     (dp_load),
        .dp_align_en (dp_align_en),
        .dp_add_en   (dp_add_en),
        .dp_norm_en  (dp_norm_en),
        .dp_round_en (dp_round_en),
        .dp_norm_done(dp_norm_done),
        .dp_result   (dp_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .busy        (busy)
    );

    always @(posedge clk) normSeen <= dp_norm_en ? normSeen + 1 : 0;
    assign dp_norm_done = dp_norm_en && (doneAt != 0) && (normSeen + 1 == doneAt);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ready"}, {30'b0, req_ready}, 32'd0);
        check({tag, "_strobes"}, {27'b0, dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_round_en},
              32'd0);
        check({tag, "_opA"}, dp_opA, 32'd0);
        check({tag, "_opB"}, dp_opB, 32'd0);
        check({tag, "_rsp"}, {29'b0, rsp_valid, rsp_timeout}, 32'd0);
        check({tag, "_data"}, rsp_data, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    // Latency is counted in cycles from the cycle in which the handshake is visible.
    task automatic doOp(input logic [1:0] valid, input int normWant, input int expN,
                        input logic expTo, input logic [31:0] result, input int hold,
                        output int gotOwner);
        int lat;
        int nNorm;
        int waitCnt;
        logic [1:0] ownHot;
        logic [4:0] expStb;
        @(negedge clk);
        doneAt    = normWant;
        dp_result = result;
        req_valid = valid;
        #1;
        waitCnt = 0;
        while (req_ready == 2'b00 && waitCnt < 10) begin
            @(negedge clk);
            #1;
            waitCnt++;
        end
        check("grant_seen", {31'b0, req_ready != 2'b00}, 32'd1);
        check("grant_onehot", $countones(req_ready & valid), 32'd1);
        gotOwner = req_ready[1] ? 1 : 0;
        ownHot   = req_ready[1] ? 2'b10 : 2'b01;
        lat   = 0;
        nNorm = 0;
        do begin
            @(negedge clk);
            if (lat == 0) req_valid = 2'b00;
            #1;
            lat++;
            if (dp_norm_en) nNorm++;
            expStb = (lat == 1) ? 5'b10000 : (lat == 2) ? 5'b01000 : (lat == 3) ? 5'b00100 :
                     (lat <= 3 + expN) ? 5'b00010 : (lat == 4 + expN) ? 5'b00001 : 5'b00000;
            check("strobes", {27'b0, dp_load, dp_align_en, dp_add_en, dp_norm_en, dp_round_en},
                  {27'b0, expStb});
            if (lat == 1) begin
                check("opA", dp_opA, gotOwner == 1 ? req_a1 : req_a0);
                check("opB", dp_opB, gotOwner == 1 ? req_b1 : req_b0);
                check("busy_run", {31'b0, busy}, 32'd1);
            end
        end while (rsp_valid == 2'b00 && lat < 60);
        check("latency", lat, 5 + expN);
        check("norm_cycles", nNorm, expN);
        check("rsp_valid", {30'b0, rsp_valid}, {30'b0, ownHot});
        check("rsp_data", rsp_data, result);
        check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, expTo});
        // Disturb the datapath and the non-owner ready; the held response must not move.
        dp_result = ~result;
        req_valid = 2'b11;
        rsp_ready = ~ownHot;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            check("hold_valid", {30'b0, rsp_valid}, {30'b0, ownHot});
            check("hold_data", rsp_data, result);
            check("hold_timeout", {31'b0, rsp_timeout}, {31'b0, expTo});
            check("hold_busy", {31'b0, busy}, 32'd1);
            check("hold_ready", {30'b0, req_ready}, 32'd0);
        end
        req_valid = 2'b00;
        rsp_ready = ownHot;
        @(negedge clk);
        #1;
        check("release_valid", {30'b0, rsp_valid}, 32'd0);
        check("release_busy", {31'b0, busy}, 32'd0);
        rsp_ready = 2'b00;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int owner;
        int nNorm;
        int guard;
        int sawRsp;
        int expOrder [3];
`ifdef FPADD_SCHED_RR_EN
        expOrder = '{0, 1, 0};
`else
        expOrder = '{0, 0, 0};
`endif
        reset     = 1'b1;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        req_a0 = 32'h3F80_0000;  req_b0 = 32'h3F80_0000;
        req_a1 = 32'h4040_0000;  req_b1 = 32'h4080_0000;
        dp_result = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;

        // 1.0 + 1.0 = 2.0, done on the first NORM cycle.
        doOp(2'b01, 1, 1, 1'b0, 32'h4000_0000, 0, owner);
        check("owner_basic", owner, 0);

        // Contention for three operations after a fresh reset. Requester 1: 3.0 + 4.0 = 7.0.
        applyReset();
        req_a0 = 32'h3F80_0000;  req_b0 = 32'h4000_0000;
        for (int k = 0; k < 3; k++) begin
            doOp(2'b11, 2, 2, 1'b0, expOrder[k] == 1 ? 32'h40E0_0000 : 32'h4040_0000, 0, owner);
            check("grant_order", owner, expOrder[k]);
        end

        // Requester 1 alone, response held for 5 cycles.
        doOp(2'b10, 3, 3, 1'b0, 32'h40E0_0000, 5, owner);
        check("owner_hold", owner, 1);

        // Done never arrives: 24 NORM cycles then timeout.
        doOp(2'b01, 0, 24, 1'b1, 32'h4040_0000, 1, owner);
        // Done coincides with the limit cycle: done wins.
        doOp(2'b01, 24, 24, 1'b0, 32'h4040_0000, 0, owner);

        // Reset in the 3rd NORM cycle.
        @(negedge clk);
        doneAt    = 0;
        req_valid = 2'b01;
        #1;
        guard = 0;
        while (req_ready == 2'b00 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("rst_grant", {30'b0, req_ready}, 32'd1);
        nNorm = 0;
        guard = 0;
        while (nNorm < 3 && guard < 20) begin
            @(negedge clk);
            req_valid = 2'b00;
            #1;
            guard++;
            if (dp_norm_en) nNorm++;
        end
        check("rst_norm_reached", nNorm, 3);
        reset = 1'b1;
        #1;
        checkIdleOutputs("midreset");
        @(negedge clk);
        reset  = 1'b0;
        sawRsp = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != 2'b00 || busy) sawRsp++;
        end
        check("no_rsp_after_reset", sawRsp, 0);
        doOp(2'b01, 1, 1, 1'b0, 32'h4040_0000, 0, owner);
        check("owner_after_reset", owner, 0);

        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
